// File: rtl/williams2_nvram.sv
// Battery-backed 2^ADDR_W x 4 CMOS store: CPU port A, HPS ioctl port B (download, waited upload).
// Raises a one-cycle ioctl_upload_req after CPU writes go quiet, or on save_now, so the file gets saved.
module williams2_nvram #(
  parameter int         ADDR_W       = 10,
  parameter logic [7:0] NV_INDEX     = 8'd4,
  parameter int         QUIET_CYCLES = 48_000_000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_din,
  output logic [3:0]        cpu_dout,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [16:0]       ioctl_addr,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              autosave_en,
  input  logic              save_now,
  output logic              nv_loaded
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [16:0]     DEPTH17  = 17'(DEPTH);
  localparam int              QW       = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0]   QUIET_LD = QW'(QUIET_CYCLES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  logic [3:0] mem [DEPTH];
  logic [3:0] b_q;

  logic       sel, dl_we, dl_done;
  logic       unused_hi;
  logic [1:0] state_q, state_d;
  logic [16:0] b_addr_q, b_addr_d;
  logic       wait_q, wait_d;
  logic [7:0] din_q, din_d;
  logic [3:0] cpu_dout_q;
  logic       dl_prev_q, nv_loaded_q;
  logic       dirty_q, dirty_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic       req_q, req_d;

  assign sel       = (ioctl_index == NV_INDEX);
  assign dl_we     = ioctl_wr && ioctl_download && sel && (ioctl_addr < DEPTH17);
  assign dl_done   = dl_prev_q && !ioctl_download && sel;
  assign unused_hi = ^ioctl_dout[7:4];

  // Second assignment wins on a same-address collision, so the download beats the CPU.
  always_ff @(posedge clk_sys) begin
    if (cpu_we) mem[cpu_addr] <= cpu_din;
    if (dl_we)  mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout[3:0];
    b_q <= mem[b_addr_q[ADDR_W-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    b_addr_d = b_addr_q;
    wait_d   = wait_q;
    din_d    = din_q;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_rd && ioctl_upload && sel) begin
          state_d  = ST_FETCH;
          wait_d   = 1'b1;
          b_addr_d = ioctl_addr;
        end
      end
      ST_FETCH: state_d = ST_PRESENT;
      ST_PRESENT: begin
        din_d   = (b_addr_q < DEPTH17) ? {4'h0, b_q} : 8'h00;
        wait_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Later assignments take priority: a CPU write always leaves the store dirty with a fresh timer.
  always_comb begin
    dirty_d = dirty_q;
    quiet_d = quiet_q;
    req_d   = 1'b0;
    if (dirty_q && quiet_q != '0) quiet_d = quiet_q - QW'(1);
    if (!ioctl_upload && !ioctl_download &&
        (save_now || (dirty_q && quiet_q == '0 && autosave_en))) begin
      req_d   = 1'b1;
      dirty_d = 1'b0;
    end
    if (dl_done) dirty_d = 1'b0;
    if (cpu_we) begin
      dirty_d = 1'b1;
      quiet_d = QUIET_LD;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      b_addr_q    <= '0;
      wait_q      <= 1'b0;
      din_q       <= 8'h00;
      cpu_dout_q  <= 4'h0;
      dl_prev_q   <= 1'b0;
      nv_loaded_q <= 1'b0;
      dirty_q     <= 1'b0;
      quiet_q     <= '0;
      req_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_addr_q   <= b_addr_d;
      wait_q     <= wait_d;
      din_q      <= din_d;
      cpu_dout_q <= mem[cpu_addr];
      dl_prev_q  <= ioctl_download;
      if (dl_done) nv_loaded_q <= 1'b1;
      dirty_q    <= dirty_d;
      quiet_q    <= quiet_d;
      req_q      <= req_d;
    end
  end

  assign cpu_dout         = cpu_dout_q;
  assign ioctl_din        = din_q;
  assign ioctl_wait       = wait_q;
  assign ioctl_upload_req = req_q;
  assign nv_loaded        = nv_loaded_q;
endmodule

// File: tb/tb_williams2_nvram.sv
// Directed bench for williams2_nvram with a short quiet period.
module tb_williams2_nvram;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [9:0]  cpu_addr;
  logic        cpu_we;
  logic [3:0]  cpu_din;
  logic [3:0]  cpu_dout;
  logic        ioctl_download, ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [16:0] ioctl_addr;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait, ioctl_upload_req;
  logic        autosave_en, save_now, nv_loaded;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  williams2_nvram #(.ADDR_W(10), .NV_INDEX(8'd4), .QUIET_CYCLES(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .ioctl_upload_req(ioctl_upload_req),
    .autosave_en(autosave_en), .save_now(save_now), .nv_loaded(nv_loaded)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cpu_addr = '0; cpu_we = 1'b0; cpu_din = '0;
    ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd4;
    ioctl_addr = '0; ioctl_wr = 1'b0; ioctl_dout = '0; ioctl_rd = 1'b0;
    autosave_en = 1'b0; save_now = 1'b0;
    tick(2);
    vec_cnt++; if (cpu_dout !== 4'h0) begin err_cnt++; $display("FAIL reset_cpu_dout got %h want 0", cpu_dout); end
    vec_cnt++; if (ioctl_din !== 8'h00) begin err_cnt++; $display("FAIL reset_ioctl_din got %h want 00", ioctl_din); end
    vec_cnt++; if (ioctl_wait !== 1'b0) begin err_cnt++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    vec_cnt++; if (ioctl_upload_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req got %b want 0", ioctl_upload_req); end
    vec_cnt++; if (nv_loaded !== 1'b0) begin err_cnt++; $display("FAIL reset_nv_loaded got %b want 0", nv_loaded); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_rw;
    cpu_addr = 10'h123; cpu_din = 4'hA; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    tick();
    vec_cnt++; if (cpu_dout !== 4'hA) begin err_cnt++; $display("FAIL cpu_read_123 got %h want a", cpu_dout); end
    cpu_din = 4'h6; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    vec_cnt++; if (cpu_dout !== 4'hA) begin err_cnt++; $display("FAIL cpu_rdw_old got %h want a", cpu_dout); end
    tick();
    vec_cnt++; if (cpu_dout !== 4'h6) begin err_cnt++; $display("FAIL cpu_read_new got %h want 6", cpu_dout); end
  endtask

  task automatic test_download;
    cpu_addr = 10'd5; cpu_din = 4'h2; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    // Wrong index: neither the write nor the completion edge should count.
    ioctl_index = 8'd3; ioctl_download = 1'b1;
    ioctl_addr = 17'd5; ioctl_dout = 8'h49; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    vec_cnt++; if (nv_loaded !== 1'b0) begin err_cnt++; $display("FAIL dl_idx3_nv_loaded got %b want 0", nv_loaded); end
    tick();
    vec_cnt++; if (cpu_dout !== 4'h2) begin err_cnt++; $display("FAIL dl_idx3_mem5 got %h want 2", cpu_dout); end

    ioctl_index = 8'd4; ioctl_download = 1'b1;
    ioctl_addr = 17'd0; ioctl_dout = 8'h5F; ioctl_wr = 1'b1;
    tick();
    ioctl_addr = 17'd1023; ioctl_dout = 8'h37;
    cpu_addr = 10'd1023; cpu_din = 4'h1; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    ioctl_addr = 17'd1024; ioctl_dout = 8'h3C;
    tick();
    ioctl_wr = 1'b0;
    vec_cnt++; if (nv_loaded !== 1'b0) begin err_cnt++; $display("FAIL dl_nv_loaded_early got %b want 0", nv_loaded); end
    ioctl_download = 1'b0;
    tick();
    vec_cnt++; if (nv_loaded !== 1'b1) begin err_cnt++; $display("FAIL dl_nv_loaded got %b want 1", nv_loaded); end
    cpu_addr = 10'd0;
    tick();
    vec_cnt++; if (cpu_dout !== 4'hF) begin err_cnt++; $display("FAIL dl_mem0 got %h want f", cpu_dout); end
    cpu_addr = 10'd1023;
    tick();
    vec_cnt++; if (cpu_dout !== 4'h7) begin err_cnt++; $display("FAIL dl_mem1023_collision got %h want 7", cpu_dout); end
  endtask

  task automatic test_upload;
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    ioctl_addr = 17'd1023; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    vec_cnt++; if (ioctl_wait !== 1'b1) begin err_cnt++; $display("FAIL up_wait_1 got %b want 1", ioctl_wait); end
    ioctl_addr = 17'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    vec_cnt++; if (ioctl_wait !== 1'b1) begin err_cnt++; $display("FAIL up_wait_2 got %b want 1", ioctl_wait); end
    tick();
    vec_cnt++; if (ioctl_wait !== 1'b0) begin err_cnt++; $display("FAIL up_wait_done got %b want 0", ioctl_wait); end
    vec_cnt++; if (ioctl_din !== 8'h07) begin err_cnt++; $display("FAIL up_din_1023 got %h want 07", ioctl_din); end
    tick();
    vec_cnt++; if (ioctl_wait !== 1'b0) begin err_cnt++; $display("FAIL up_ignored_rd_wait got %b want 0", ioctl_wait); end
    vec_cnt++; if (ioctl_din !== 8'h07) begin err_cnt++; $display("FAIL up_din_hold got %h want 07", ioctl_din); end

    ioctl_addr = 17'd2000; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick(2);
    vec_cnt++; if (ioctl_wait !== 1'b0) begin err_cnt++; $display("FAIL up_oor_wait got %b want 0", ioctl_wait); end
    vec_cnt++; if (ioctl_din !== 8'h00) begin err_cnt++; $display("FAIL up_oor_din got %h want 00", ioctl_din); end

    ioctl_index = 8'd3; ioctl_addr = 17'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    vec_cnt++; if (ioctl_wait !== 1'b0) begin err_cnt++; $display("FAIL up_nosel_wait got %b want 0", ioctl_wait); end
    tick(2);
    vec_cnt++; if (ioctl_din !== 8'h00) begin err_cnt++; $display("FAIL up_nosel_din got %h want 00", ioctl_din); end
    ioctl_upload = 1'b0; ioctl_index = 8'd4;
  endtask

  task automatic test_autosave;
    logic seen;
    autosave_en = 1'b1;
    cpu_addr = 10'h10; cpu_din = 4'h1; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    tick(9);
    cpu_din = 4'h2; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    // Pulse is due 17 edges after the final write.
    for (int k = 1; k <= 18; k++) begin
      tick();
      vec_cnt++;
      if (ioctl_upload_req !== (k == 17)) begin
        err_cnt++;
        $display("FAIL autosave_req_t%0d got %b want %b", k, ioctl_upload_req, (k == 17));
      end
    end

    autosave_en = 1'b0;
    cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ioctl_upload_req) seen = 1'b1;
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL autosave_disabled got pulse=%b want 0", seen); end
    autosave_en = 1'b1;
    tick();
    vec_cnt++; if (ioctl_upload_req !== 1'b1) begin err_cnt++; $display("FAIL autosave_still_dirty got %b want 1", ioctl_upload_req); end
    tick();
    vec_cnt++; if (ioctl_upload_req !== 1'b0) begin err_cnt++; $display("FAIL autosave_single got %b want 0", ioctl_upload_req); end
    autosave_en = 1'b0;
  endtask

  task automatic test_manual_save;
    save_now = 1'b1;
    tick();
    save_now = 1'b0;
    vec_cnt++; if (ioctl_upload_req !== 1'b1) begin err_cnt++; $display("FAIL save_now_clean got %b want 1", ioctl_upload_req); end
    tick();
    vec_cnt++; if (ioctl_upload_req !== 1'b0) begin err_cnt++; $display("FAIL save_now_single got %b want 0", ioctl_upload_req); end
    ioctl_upload = 1'b1; save_now = 1'b1;
    tick();
    save_now = 1'b0;
    vec_cnt++; if (ioctl_upload_req !== 1'b0) begin err_cnt++; $display("FAIL save_now_upload got %b want 0", ioctl_upload_req); end
    tick();
    vec_cnt++; if (ioctl_upload_req !== 1'b0) begin err_cnt++; $display("FAIL save_now_upload_late got %b want 0", ioctl_upload_req); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_async_reset;
    ioctl_index = 8'd4; ioctl_upload = 1'b1; ioctl_addr = 17'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    vec_cnt++; if (ioctl_wait !== 1'b1) begin err_cnt++; $display("FAIL arst_wait_before got %b want 1", ioctl_wait); end
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++; if (ioctl_wait !== 1'b0) begin err_cnt++; $display("FAIL arst_wait_async got %b want 0", ioctl_wait); end
    vec_cnt++; if (nv_loaded !== 1'b0) begin err_cnt++; $display("FAIL arst_nv_loaded got %b want 0", nv_loaded); end
    #3 reset_n = 1'b1;
    ioctl_upload = 1'b0;
    cpu_addr = 10'd0;
    tick();
    vec_cnt++; if (cpu_dout !== 4'hF) begin err_cnt++; $display("FAIL arst_mem0 got %h want f", cpu_dout); end
    cpu_addr = 10'h123;
    tick();
    vec_cnt++; if (cpu_dout !== 4'h6) begin err_cnt++; $display("FAIL arst_mem123 got %h want 6", cpu_dout); end
    cpu_addr = 10'd1023;
    tick();
    vec_cnt++; if (cpu_dout !== 4'h7) begin err_cnt++; $display("FAIL arst_mem1023 got %h want 7", cpu_dout); end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_download();
    test_upload();
    test_autosave();
    test_manual_save();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
